// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
// Contents: the funct3 operation encoding, the control FSM states, the
// opcode/funct7 constants a decoder uses to route an instruction here, and
// small helpers that classify an operation by signedness and type.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } muldiv_state_e;

    localparam logic [6:0] MULDIV_OPCODE = 7'b0110011;
    localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

    // rs1 is treated as two's complement for these ops.
    function automatic logic a_is_signed(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // rs2 is treated as two's complement for these ops (MULHSU keeps it unsigned).
    function automatic logic b_is_signed(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_div(input muldiv_op_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_abs_neg.sv
// Conditional two's-complement negate.
// Ports: in_i  - value to transform
//        neg_i - 1: output is -in_i, 0: output is in_i
//        out_o - result, same width as in_i
module muldiv_abs_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] in_i,
    input  logic         neg_i,
    output logic [W-1:0] out_o
);

    assign out_o = neg_i ? (~in_i + W'(1)) : in_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, on operand magnitudes; signs are
// reapplied in a final FIX cycle.
// Ports: clk, rst_n (async, active low)
//        start/ready  - request handshake, accepted when start && ready
//        kill         - abort an in-flight op without a done pulse
//        op           - funct3 of the M-extension instruction
//        op_a, op_b   - rs1 / rs2 operands, sampled only on accept
//        busy         - op in flight (inverse of ready)
//        done         - one-cycle pulse, result valid
//        result       - last completed result, held between ops
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int LEN = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           kill,
    input  logic [2:0]     op,
    input  logic [LEN-1:0] op_a,
    input  logic [LEN-1:0] op_b,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic [LEN-1:0] result
);

    localparam int CNT_W = $clog2(LEN) + 1;

    muldiv_state_e   state_q, state_d;
    muldiv_op_e      op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // hi: product high half / partial remainder. lo: multiplier shifting
    // out into product low half / dividend shifting out into quotient.
    logic [LEN-1:0]  hi_q, hi_d;
    logic [LEN-1:0]  lo_q, lo_d;
    logic [LEN-1:0]  bop_q, bop_d;
    logic            psign_q, psign_d;   // product / quotient sign
    logic            rsign_q, rsign_d;   // remainder sign
    logic [LEN-1:0]  result_q, result_d;
    logic            done_q, done_d;

    // ---------------- operand entry ----------------
    muldiv_op_e     op_in;
    logic           neg_a_in, neg_b_in;
    logic [LEN-1:0] a_mag, b_mag;
    logic           div_by_zero, div_overflow;

    assign op_in    = muldiv_op_e'(op);
    assign neg_a_in = a_is_signed(op_in) & op_a[LEN-1];
    assign neg_b_in = b_is_signed(op_in) & op_b[LEN-1];

    muldiv_abs_neg #(.W(LEN)) u_abs_a (.in_i(op_a), .neg_i(neg_a_in), .out_o(a_mag));
    muldiv_abs_neg #(.W(LEN)) u_abs_b (.in_i(op_b), .neg_i(neg_b_in), .out_o(b_mag));

    assign div_by_zero  = op_is_div(op_in) && (op_b == '0);
    assign div_overflow = ((op_in == OP_DIV) || (op_in == OP_REM))
                          && (op_a == {1'b1, {(LEN-1){1'b0}}}) && (op_b == '1);

    // ---------------- iteration datapath ----------------
    logic [LEN:0] mul_sum;
    logic [LEN:0] rem_sh;
    logic [LEN:0] div_diff;

    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, bop_q} : '0);
    assign rem_sh   = {hi_q, lo_q[LEN-1]};
    // Negative trial difference (MSB set) means the divisor did not fit.
    assign div_diff = rem_sh - {1'b0, bop_q};

    // ---------------- sign fix-up ----------------
    logic [2*LEN-1:0] prod_fix;
    logic [LEN-1:0]   quot_fix, rem_fix;
    logic [LEN-1:0]   fix_result;

    muldiv_abs_neg #(.W(2*LEN)) u_neg_prod (.in_i({hi_q, lo_q}), .neg_i(psign_q), .out_o(prod_fix));
    muldiv_abs_neg #(.W(LEN))   u_neg_quot (.in_i(lo_q),         .neg_i(psign_q), .out_o(quot_fix));
    muldiv_abs_neg #(.W(LEN))   u_neg_rem  (.in_i(hi_q),         .neg_i(rsign_q), .out_o(rem_fix));

    always_comb begin
        fix_result = '0;
        case (op_q)
            OP_MUL:                        fix_result = prod_fix[LEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_result = prod_fix[2*LEN-1:LEN];
            OP_DIV, OP_DIVU:               fix_result = quot_fix;
            default:                       fix_result = rem_fix;
        endcase
    end

    // ---------------- control FSM ----------------
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        bop_d    = bop_q;
        psign_d  = psign_q;
        rsign_d  = rsign_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !kill) begin
                    op_d    = op_in;
                    cnt_d   = '0;
                    hi_d    = '0;
                    lo_d    = a_mag;
                    bop_d   = b_mag;
                    psign_d = neg_a_in ^ neg_b_in;
                    rsign_d = neg_a_in;
                    state_d = ST_CALC;
                    // Special cases preload quotient/remainder so FIX
                    // passes them through unchanged.
                    if (div_by_zero) begin
                        lo_d    = '1;
                        hi_d    = op_a;
                        psign_d = 1'b0;
                        rsign_d = 1'b0;
                        state_d = ST_FIX;
                    end else if (div_overflow) begin
                        lo_d    = op_a;
                        hi_d    = '0;
                        psign_d = 1'b0;
                        rsign_d = 1'b0;
                        state_d = ST_FIX;
                    end
                end
            end
            ST_CALC: begin
                if (kill) begin
                    state_d = ST_IDLE;
                end else begin
                    if (op_is_div(op_q)) begin
                        if (!div_diff[LEN]) begin
                            hi_d = div_diff[LEN-1:0];
                            lo_d = {lo_q[LEN-2:0], 1'b1};
                        end else begin
                            hi_d = rem_sh[LEN-1:0];
                            lo_d = {lo_q[LEN-2:0], 1'b0};
                        end
                    end else begin
                        hi_d = mul_sum[LEN:1];
                        lo_d = {mul_sum[0], lo_q[LEN-1:1]};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(LEN - 1)) begin
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!kill) begin
                    done_d   = 1'b1;
                    result_d = fix_result;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            bop_q    <= '0;
            psign_q  <= 1'b0;
            rsign_q  <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            bop_q    <= bop_d;
            psign_q  <= psign_d;
            rsign_q  <= rsign_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign ready  = (state_q == ST_IDLE);
    assign busy   = !ready;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver pushes hand-computed
// results and completion edges; a negedge monitor pops and compares on done.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int LEN = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           kill = 1'b0;
    logic [2:0]     op = 3'b000;
    logic [LEN-1:0] op_a = '0;
    logic [LEN-1:0] op_b = '0;
    logic           ready, busy, done;
    logic [LEN-1:0] result;

    muldiv_unit #(.LEN(LEN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .kill(kill), .op(op),
        .op_a(op_a), .op_b(op_b), .ready(ready), .busy(busy),
        .done(done), .result(result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [LEN-1:0] res;
        int             edge_n;
        string          name;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   done_cnt = 0;

    task automatic chk(input string name, input logic [LEN-1:0] act, input logic [LEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at edge %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_result"}, result, e.res);
                chk({e.name, "_done_edge"}, LEN'(cyc), LEN'(e.edge_n));
                $display("txn %s: result=%h done_edge=%0d", e.name, result, cyc);
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [LEN-1:0] a, input logic [LEN-1:0] b,
                         input logic [LEN-1:0] exp, input bit special, input bit push,
                         input string name, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL %s_ready_wait: got ready=0 expected 1 within 200 cycles", name);
        end
        start = 1'b1;
        op    = o;
        op_a  = a;
        op_b  = b;
        @(posedge clk);
        #1;
        acc = cyc;
        if (push) sb.push_back('{exp, acc + (special ? 1 : LEN + 1), name});
        start = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int acc, acc2, dc, n;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", LEN'(ready), 1);
        chk("rst_busy", LEN'(busy), 0);
        chk("rst_done", LEN'(done), 0);
        chk("rst_result", result, 0);
        rst_n = 1'b1;

        // MUL 7x6 with ready-low window: low after edges 0..32, high after 33
        issue(OP_MUL, 7, 6, 42, 0, 1, "mul_7x6", acc);
        n = 0;
        for (int i = 0; i <= 32; i++) begin
            @(negedge clk);
            if (ready !== 1'b0 || busy !== 1'b1) n++;
        end
        chk("mul_ready_low_cycles_bad", LEN'(n), 0);
        @(negedge clk);
        chk("mul_ready_high_after", LEN'(ready), 1);

        issue(OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0, 1, "mulh_m1m1", acc);
        issue(OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, 1, "mul_m1m1", acc);
        issue(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 1, "mulhu_max", acc);
        issue(OP_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 0, 1, "mulhsu_m1x2", acc);
        issue(OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 0, 1, "mulh_min", acc);
        issue(OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 0, 1, "div_m7_2", acc);
        issue(OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 0, 1, "rem_m7_2", acc);
        issue(OP_DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 0, 1, "div_7_m2", acc);
        issue(OP_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001, 0, 1, "rem_7_m2", acc);
        issue(OP_DIVU,   100, 7, 14, 0, 1, "divu_100_7", acc);
        issue(OP_REMU,   100, 7, 2, 0, 1, "remu_100_7", acc);

        // Special cases complete at edge 1
        issue(OP_DIVU, 5, 0, 32'hFFFFFFFF, 1, 1, "divu_5_0", acc);
        issue(OP_REM,  5, 0, 5, 1, 1, "rem_5_0", acc);
        issue(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1, "div_ovf", acc);
        issue(OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 1, "rem_ovf", acc);

        // Back-to-back: second op accepted at the edge ending the done cycle
        issue(OP_MUL,  3, 5, 15, 0, 1, "b2b_mul", acc);
        issue(OP_DIVU, 100, 7, 14, 0, 1, "b2b_divu", acc2);
        chk("b2b_accept_edge", LEN'(acc2 - acc), LEN'(LEN + 2));

        // kill mid-DIV, with a start while busy that must be ignored
        issue(OP_DIV, 32'hFFFFFF9C, 3, 0, 0, 0, "div_killed", acc);
        repeat (4) @(negedge clk);
        start = 1'b1; op = OP_MUL; op_a = 1; op_b = 1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        dc = done_cnt;
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        @(negedge clk);
        chk("kill_ready", LEN'(ready), 1);
        chk("kill_done", LEN'(done), 0);
        chk("kill_result_held", result, 14);
        repeat (40) @(negedge clk);
        chk("kill_no_done", LEN'(done_cnt - dc), 0);

        // kill && start in IDLE: kill wins
        dc = done_cnt;
        @(negedge clk);
        kill = 1'b1; start = 1'b1; op = OP_MUL; op_a = 2; op_b = 2;
        @(posedge clk);
        #1;
        kill = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("killstart_ready", LEN'(ready), 1);
        repeat (40) @(negedge clk);
        chk("killstart_no_done", LEN'(done_cnt - dc), 0);

        // Asynchronous reset between edges mid-MUL
        issue(OP_MUL, 9, 9, 81, 0, 0, "mul_reset", acc);
        dc = done_cnt;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", LEN'(ready), 1);
        chk("arst_busy", LEN'(busy), 0);
        chk("arst_done", LEN'(done), 0);
        chk("arst_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("arst_no_done", LEN'(done_cnt - dc), 0);

        // Drain scoreboard
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_left", LEN'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
